// File: rtl/demux_pkg.sv
// Shared constants and types for the demux_stream 1-to-2 stream demultiplexer.
package demux_pkg;

  localparam logic DEST_A = 1'b0;
  localparam logic DEST_B = 1'b1;

  localparam int N_DEF     = 32;
  localparam int CNT_W_DEF = 16;

  typedef enum logic {
    SLICE_EMPTY = 1'b0,
    SLICE_FULL  = 1'b1
  } slice_state_e;

endpackage

// File: rtl/demux_out_slice.sv
// One-entry registered output slice with load/drain; transfer counter when DEMUX_COUNT_EN is defined.
module demux_out_slice
  import demux_pkg::*;
#(
  parameter int N = N_DEF
`ifdef DEMUX_COUNT_EN
  ,
  parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_data,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_valid,
  output slice_state_e state
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  slice_state_e state_q, state_d;
  logic [N-1:0] data_q, data_d;
  logic         drain;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    drain   = (state_q == SLICE_FULL) && out_ready;
    case (state_q)
      SLICE_EMPTY: begin
        if (load) begin
          state_d = SLICE_FULL;
          data_d  = load_data;
        end
      end
      SLICE_FULL: begin
        // A load into a full slice only happens when it drains the same cycle.
        if (load) begin
          data_d = load_data;
        end else if (drain) begin
          state_d = SLICE_EMPTY;
        end
      end
      default: state_d = SLICE_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SLICE_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = (state_q == SLICE_FULL);
  assign state     = state_q;

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q + CNT_W'(drain);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: rtl/demux_stream.sv
// 1-to-2 stream demultiplexer: input steered to slice A or B by command.
// Optional per-channel transfer counters under DEMUX_COUNT_EN.
module demux_stream
  import demux_pkg::*;
#(
  parameter int N = N_DEF
`ifdef DEMUX_COUNT_EN
  ,
  parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         command,
  output logic [N-1:0] out_a_data,
  output logic         out_a_valid,
  input  logic         out_a_ready,
  output logic [N-1:0] out_b_data,
  output logic         out_b_valid,
  input  logic         out_b_ready
`ifdef DEMUX_COUNT_EN
  ,
  output logic [CNT_W-1:0] count_a,
  output logic [CNT_W-1:0] count_b
`endif
);

  // Handshake: a transfer happens on any posedge where valid & ready are both 1;
  // in_ready only looks at the slice chosen by the current command.
  slice_state_e state_a, state_b;
  logic         full_sel, ready_sel;
  logic         load_a, load_b;

  always_comb begin
    full_sel  = (command == DEST_B) ? (state_b == SLICE_FULL) : (state_a == SLICE_FULL);
    ready_sel = (command == DEST_B) ? out_b_ready : out_a_ready;
    in_ready  = !rst && (!full_sel || ready_sel);
    load_a    = in_valid && in_ready && (command == DEST_A);
    load_b    = in_valid && in_ready && (command == DEST_B);
  end

  demux_out_slice #(
    .N(N)
`ifdef DEMUX_COUNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_slice_a (
    .clk      (clk),
    .rst      (rst),
    .load     (load_a),
    .load_data(in_data),
    .out_ready(out_a_ready),
    .out_data (out_a_data),
    .out_valid(out_a_valid),
    .state    (state_a)
`ifdef DEMUX_COUNT_EN
    ,
    .count    (count_a)
`endif
  );

  demux_out_slice #(
    .N(N)
`ifdef DEMUX_COUNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) u_slice_b (
    .clk      (clk),
    .rst      (rst),
    .load     (load_b),
    .load_data(in_data),
    .out_ready(out_b_ready),
    .out_data (out_b_data),
    .out_valid(out_b_valid),
    .state    (state_b)
`ifdef DEMUX_COUNT_EN
    ,
    .count    (count_b)
`endif
  );

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: directed steps plus a random phase, checked against per-destination expected queues.
module tb_demux_stream;

  localparam int N     = 32;
  localparam int CNT_W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         command;
  logic [N-1:0] out_a_data, out_b_data;
  logic         out_a_valid, out_b_valid;
  logic         out_a_ready, out_b_ready;
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] count_a, count_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0]     exp_a_q[$];
  logic [N-1:0]     exp_b_q[$];
  logic [CNT_W-1:0] cnt_a_m = '0;
  logic [CNT_W-1:0] cnt_b_m = '0;

  // clock / reset block
  always #5 clk = ~clk;

  demux_stream #(
    .N(N)
`ifdef DEMUX_COUNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .command    (command),
    .out_a_data (out_a_data),
    .out_a_valid(out_a_valid),
    .out_a_ready(out_a_ready),
    .out_b_data (out_b_data),
    .out_b_valid(out_b_valid),
    .out_b_ready(out_b_ready)
`ifdef DEMUX_COUNT_EN
    ,
    .count_a    (count_a),
    .count_b    (count_b)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic cmd, input logic [N-1:0] d);
    in_valid = v;
    command  = cmd;
    in_data  = d;
  endtask

  // scoreboard: compare against queue heads, then pop drains, then push accepted inputs
  always @(negedge clk) begin
    logic full_a, full_b, sel_full, sel_rdy, exp_rdy;
    if (rst) begin
      check("in_ready_in_reset", 64'(in_ready), 64'd0);
      exp_a_q.delete();
      exp_b_q.delete();
      cnt_a_m = '0;
      cnt_b_m = '0;
    end else begin
      full_a = (exp_a_q.size() != 0);
      full_b = (exp_b_q.size() != 0);
      check("sb_a_valid", 64'(out_a_valid), 64'(full_a));
      check("sb_b_valid", 64'(out_b_valid), 64'(full_b));
      if (full_a) check("sb_a_data", 64'(out_a_data), 64'(exp_a_q[0]));
      if (full_b) check("sb_b_data", 64'(out_b_data), 64'(exp_b_q[0]));
      sel_full = command ? full_b : full_a;
      sel_rdy  = command ? out_b_ready : out_a_ready;
      exp_rdy  = !sel_full || sel_rdy;
      check("sb_in_ready", 64'(in_ready), 64'(exp_rdy));
`ifdef DEMUX_COUNT_EN
      check("sb_count_a", 64'(count_a), 64'(cnt_a_m));
      check("sb_count_b", 64'(count_b), 64'(cnt_b_m));
`endif
      if (full_a && out_a_ready) begin
        void'(exp_a_q.pop_front());
        cnt_a_m = cnt_a_m + 1'b1;
      end
      if (full_b && out_b_ready) begin
        void'(exp_b_q.pop_front());
        cnt_b_m = cnt_b_m + 1'b1;
      end
      if (in_valid && exp_rdy) begin
        if (command) exp_b_q.push_back(in_data);
        else         exp_a_q.push_back(in_data);
      end
    end
  end

  initial begin
    // reset held 2 cycles with in_valid=1
    rst = 1'b1;
    out_a_ready = 1'b0;
    out_b_ready = 1'b0;
    drive_in(1'b1, 1'b0, 32'h1234);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    step();
    step();
    rst = 1'b0;
    drive_in(1'b0, 1'b0, '0);
    @(negedge clk);
    check("reset_a_valid", 64'(out_a_valid), 64'd0);
    check("reset_b_valid", 64'(out_b_valid), 64'd0);
    check("reset_a_data", 64'(out_a_data), 64'd0);
    check("reset_b_data", 64'(out_b_data), 64'd0);
`ifdef DEMUX_COUNT_EN
    check("reset_count_a", 64'(count_a), 64'd0);
    check("reset_count_b", 64'(count_b), 64'd0);
`endif

    // single routed transfer to A, then a stalled second A request
    step();
    drive_in(1'b1, 1'b0, 32'hDEADBEEF);
    @(negedge clk);
    check("single_in_ready", 64'(in_ready), 64'd1);
    step();
    in_data = 32'hCAFE0001;
    @(negedge clk);
    check("single_a_valid", 64'(out_a_valid), 64'd1);
    check("single_a_data", 64'(out_a_data), 64'hDEADBEEF);
    check("single_b_valid", 64'(out_b_valid), 64'd0);
    check("single_second_a_stall", 64'(in_ready), 64'd0);
    step();
    drive_in(1'b0, 1'b1, 32'hCAFE0001);
    @(negedge clk);
    check("single_switch_to_b_ready", 64'(in_ready), 64'd1);
    check("single_a_held", 64'(out_a_data), 64'hDEADBEEF);
    step();
    out_a_ready = 1'b1;
    step();
    out_a_ready = 1'b0;

    // streaming on B with drain+load each cycle
    out_b_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive_in(1'b1, 1'b1, N'(i));
      @(negedge clk);
      check("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 1) check("stream_b_data", 64'(out_b_data), 64'(i - 1));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("stream_b_last", 64'(out_b_data), 64'd4);
    step();
    @(negedge clk);
    check("stream_b_empty", 64'(out_b_valid), 64'd0);
`ifdef DEMUX_COUNT_EN
    check("stream_count_b", 64'(count_b), 64'd4);
`endif

    // backpressure hold on B while A flows
    out_b_ready = 1'b0;
    drive_in(1'b1, 1'b1, 32'h55);
    step();
    out_a_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_in(1'b1, 1'b0, N'(32'h100 + i));
      @(negedge clk);
      check("bp_b_data", 64'(out_b_data), 64'h55);
      check("bp_b_valid", 64'(out_b_valid), 64'd1);
      check("bp_a_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) check("bp_a_data", 64'(out_a_data), 64'(32'h100 + i - 1));
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_a_last", 64'(out_a_data), 64'h104);
    step();

    // reset mid-operation with both slices full
    out_a_ready = 1'b0;
    drive_in(1'b1, 1'b0, 32'hA1);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_a_full", 64'(out_a_valid), 64'd1);
    check("midrst_b_full", 64'(out_b_valid), 64'd1);
    step();
    rst = 1'b1;
    out_a_ready = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_a_valid", 64'(out_a_valid), 64'd0);
    check("midrst_b_valid", 64'(out_b_valid), 64'd0);
`ifdef DEMUX_COUNT_EN
    check("midrst_count_a", 64'(count_a), 64'd0);
`endif
    step();

    // 17 A transfers: 4-bit counter wraps through 15 -> 0
    out_a_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive_in(1'b1, 1'b0, N'($urandom));
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    check("wrap_a_empty", 64'(out_a_valid), 64'd0);
`ifdef DEMUX_COUNT_EN
    check("wrap_count_a", 64'(count_a), 64'd1);
`endif
    step();

    // random traffic, checked by the scoreboard
    for (int i = 0; i < 300; i++) begin
      drive_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), N'($urandom));
      out_a_ready = 1'($urandom_range(0, 1));
      out_b_ready = 1'($urandom_range(0, 1));
      step();
    end
    in_valid = 1'b0;
    out_a_ready = 1'b1;
    out_b_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    check("final_a_empty", 64'(out_a_valid), 64'd0);
    check("final_b_empty", 64'(out_b_valid), 64'd0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
- 1-to-2 stream demultiplexer; the inverse of the datapath 2:1 select.
- One N-bit input stream with a valid/ready handshake is steered by `command` to output A (`command`=0) or output B (`command`=1).
- Each output has a registered one-entry slice, so both destinations are timing-isolated and backpressure independently.
- Used wherever a single producer feeds two consumers, e.g. routing a result bus to either of two downstream units.

Parameters:
- N, 32, data width in bits.
- CNT_W, 16, width of transfer counters; used only when DEMUX_COUNT_EN is defined.

Ports:
- clk  input  1  sole clock; all state updates on posedge clk.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N  input payload.
- in_valid  input  1  input payload valid.
- in_ready  output  1  block accepts the input this cycle.
- command  input  1  destination select: 0 = A, 1 = B; sampled only on an input transfer.
- out_a_data  output  N  output A payload, registered.
- out_a_valid  output  1  output A holds a payload, registered.
- out_a_ready  input  1  consumer A accepts.
- out_b_data  output  N  output B payload, registered.
- out_b_valid  output  1  output B holds a payload, registered.
- out_b_ready  input  1  consumer B accepts.
- count_a  output  CNT_W  A transfers completed; present only with DEMUX_COUNT_EN.
- count_b  output  CNT_W  B transfers completed; present only with DEMUX_COUNT_EN.

Behaviour:
- Reset (rst=1 at posedge): out_*_valid=0, out_*_data=0, count_*=0.
  - in_ready is combinational and therefore 0 during reset.
  - Reset mid-operation discards any held payload; no output transfer completes in a reset cycle.
- Each output slice has two states, EMPTY (valid=0) and FULL (valid=1):
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain with load: data replaced by the new payload.
  - FULL -> FULL on no drain: data and valid held stable.
  - Drain means valid & ready.
- in_ready = !rst & (!valid_sel | ready_sel), where sel is chosen by the current `command`. The non-selected slice never affects in_ready.
- Input transfer: in_valid & in_ready at posedge loads in_data into the selected slice.
  - The payload appears on out_x_data with out_x_valid=1 in the next cycle, i.e. latency 1.
  - Full throughput is 1 transfer/cycle when the consumer is ready.
- The non-selected slice is unaffected by an input transfer and may drain in the same cycle.
- `command` may change freely while in_valid is low, or while a transfer is stalled; in_ready follows it combinationally.
- No ordering is guaranteed between A and B; order is preserved within each destination.
- Output data must not change while out_x_valid=1 and out_x_ready=0.
- in_ready depends combinationally on out_x_ready.
  - Consumers must not derive out_x_ready from in_valid or in_ready (no combinational loop).

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined:
  - count_a/count_b increment by 1 on each completed output transfer (valid & ready) on their channel.
  - They wrap from 2^CNT_W-1 to 0 and are cleared by rst.
- Undefined:
  - Ports and counter logic are absent.
  - Handshake behaviour is identical.

Decomposition:
- Package demux_pkg:
  - destination constants DEST_A=1'b0, DEST_B=1'b1;
  - default widths N_DEF=32, CNT_W_DEF=16.
- One natural sub-module, demux_out_slice:
  - one-entry register slice with load/drain and optional counter;
  - instantiated twice, for A and B.

Test Plan:
- Reset
  - Stimulus: rst held 2 cycles with in_valid=1.
  - Required: in_ready=0; after release, out_a_valid=out_b_valid=0, out_*_data=0, count_*=0.
- Single routed transfer
  - Stimulus: in_data=0xDEADBEEF, command=0, in_valid=1, out_a_ready=0, for 1 cycle.
  - Required: next cycle out_a_valid=1, out_a_data=0xDEADBEEF, out_b_valid=0.
  - Then: a second A request gives in_ready=0; switching command=1 gives in_ready=1.
- Streaming with drain+load
  - Stimulus: command=1, out_b_ready=1, in_data 1,2,3,4 on consecutive cycles.
  - Required: out_b_data 1,2,3,4 on consecutive cycles, in_ready constantly 1, count_b=4 (with DEMUX_COUNT_EN).
- Backpressure hold
  - Stimulus: B FULL with 0x55, out_b_ready=0 for 5 cycles.
  - Required: out_b_data stays 0x55 and out_b_valid stays 1; A traffic (command=0, out_a_ready=1) flows unaffected.
- Reset mid-operation
  - Stimulus: both slices FULL, rst=1 for 1 cycle with out_a_ready=1.
  - Required: both valids 0 next cycle, and count_a is not incremented.
- Counter wrap (DEMUX_COUNT_EN, CNT_W=4)
  - Stimulus: 17 A transfers.
  - Required: count_a=1 (wrapped through 15->0).
